// File: rtl/div_result_collector.sv
// div_result_collector
//   Collects results from the last cell of a pipelined divider into a small
//   first-word-fall-through buffer for a downstream consumer.
//
//   Optional feature: define DIV_ZERO_FLAG_EN to flag zero-divisor results.
//   When it is defined, such a result is stored with div_zero=1 and an
//   all-ones quotient. When it is undefined, div_zero_o is tied to 0.
//
//   Parameters: N (dividend width), M (divisor width), DEPTH (entries, power of 2, >=2)
//   Ports:
//     clk, rstn              clock, async active-low reset
//     rdy_i                  result strobe, one result per high cycle
//     merchant_i             quotient in          [N-M:0]
//     remainder_i            remainder in         [M-1:0]
//     divisor_i              divisor in           [M-1:0]
//     out_ready              consumer accepts the head entry
//     clr_ovf                synchronous clear of overflow_o
//     out_valid              head entry present
//     quotient_o             head quotient; 0 when empty
//     remainder_o            head remainder; 0 when empty
//     div_zero_o             head came from a zero divisor; 0 when empty
//     count_o                occupancy, 0..DEPTH
//     overflow_o             sticky: a result was dropped while full
module div_result_collector #(
  parameter int N     = 5,
  parameter int M     = 3,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         rdy_i,
  input  logic [N-M:0]                 merchant_i,
  input  logic [M-1:0]                 remainder_i,
  input  logic [M-1:0]                 divisor_i,
  input  logic                         out_ready,
  input  logic                         clr_ovf,
  output logic                         out_valid,
  output logic [N-M:0]                 quotient_o,
  output logic [M-1:0]                 remainder_o,
  output logic                         div_zero_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o
);

  localparam int QW = N - M + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [QW-1:0] q_mem [DEPTH];
  logic [M-1:0]  r_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic [QW-1:0] q_in;
  logic [M-1:0]  r_in;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && out_ready;
  // A full buffer still accepts a result when the head leaves on the same edge.
  assign push  = rdy_i && (!full || pop);
  assign drop  = rdy_i && full && !pop;

`ifdef DIV_ZERO_FLAG_EN
  logic dz_in;
  logic dz_mem [DEPTH];

  assign dz_in = (divisor_i == '0);
  assign q_in  = dz_in ? '1 : merchant_i;
  assign r_in  = remainder_i;

  always_ff @(posedge clk) begin
    if (push) dz_mem[wr_ptr] <= dz_in;
  end

  assign div_zero_o = empty ? 1'b0 : dz_mem[rd_ptr];
`else
  // The divisor is only consumed by the zero-divisor flag build.
  logic unused_divisor;
  assign unused_divisor = ^divisor_i;

  assign q_in       = merchant_i;
  assign r_in       = remainder_i;
  assign div_zero_o = 1'b0;
`endif

  // Storage is not reset; empty-state gating on the outputs hides stale data.
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= q_in;
      r_mem[wr_ptr] <= r_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      // A new drop takes priority over a clear in the same cycle.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign out_valid   = !empty;
  assign quotient_o  = empty ? '0 : q_mem[rd_ptr];
  assign remainder_o = empty ? '0 : r_mem[rd_ptr];
  assign count_o     = count;
  assign overflow_o  = overflow;

endmodule

// File: doc/div_result_collector.md
DIV_RESULT_COLLECTOR -- requirements
Module: div_result_collector

Interface
REQ-001 Parameter N, default 5, total dividend width of the divider pipeline.
REQ-002 Parameter M, default 3, divisor width; quotient width is N-M+1, remainder width is M.
REQ-003 Parameter DEPTH, default 4, result buffer entries; power of two, >=2.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 rdy_i  input  1  result-valid strobe from the final divider cell; one result per high cycle.
REQ-007 merchant_i  input  N-M+1  quotient from the final cell.
REQ-008 remainder_i  input  M  remainder from the final cell.
REQ-009 divisor_i  input  M  divisor carried alongside the result by the final cell.
REQ-010 out_ready  input  1  downstream consumer accepts the head entry.
REQ-011 clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-012 out_valid  output  1  head entry present.
REQ-013 quotient_o  output  N-M+1  head-entry quotient.
REQ-014 remainder_o  output  M  head-entry remainder.
REQ-015 div_zero_o  output  1  head entry came from a zero divisor.
REQ-016 count_o  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-017 overflow_o  output  1  sticky flag: a result was dropped.

Function
REQ-018 Push: rdy_i high and (not full, or pop in the same cycle) writes {merchant, remainder, div_zero} at the write pointer on that clock edge.
REQ-019 Pop: out_valid and out_ready both high in a cycle; the head entry is retired on that edge.
REQ-020 First-word-fall-through: out_valid and head data are driven from registered storage, with no combinational path from rdy_i or data inputs to outputs.
REQ-021 Latency: a result pushed into an empty buffer at edge k gives out_valid=1 in the cycle after edge k; no same-cycle bypass.
REQ-022 Empty buffer: out_valid=0; quotient_o, remainder_o and div_zero_o read 0.
REQ-023 Full buffer with push and no pop: the incoming result is dropped, storage and count are unchanged, and overflow_o is set on that edge.
REQ-024 Full buffer with push and pop in the same cycle: both succeed, and count stays DEPTH.
REQ-025 Empty buffer with push and out_ready in the same cycle: only the push occurs, and count becomes 1.
REQ-026 Count update: count_o increments on push-only, decrements on pop-only, and holds otherwise.
REQ-027 Pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0; full/empty are derived from count, not from pointer equality.
REQ-028 overflow_o stays high until clr_ovf; if clr_ovf and a new drop occur in the same cycle, set wins.
REQ-029 Data is passed through unmodified except as described under Configuration.

Reset
REQ-030 rstn low asynchronously clears pointers, count_o, out_valid and overflow_o to 0; quotient_o, remainder_o and div_zero_o read 0.
REQ-031 Reset asserted mid-operation discards all buffered entries; the first push after rstn deasserts behaves as a push into an empty buffer.
REQ-032 Storage array contents need no reset, because empty-state output gating (REQ-022) hides them.

Configuration
REQ-033 Macro DIV_ZERO_FLAG_EN defined: a push with divisor_i==0 stores div_zero=1, quotient all-ones and remainder equal to remainder_i.
REQ-034 Macro DIV_ZERO_FLAG_EN undefined: div_zero_o is tied to 0, no zero-divisor logic is built, and merchant/remainder are stored raw.

Verification
REQ-035 Single result: push q=5, r=2, divisor=3 with out_ready=0 -> out_valid=1 next cycle, quotient_o=5, remainder_o=2, count_o=1.
REQ-036 Fill and overflow: 5 consecutive pushes q=0..4 with out_ready=0 and DEPTH=4 -> count_o=4, overflow_o=1 after the 5th push, and pops return 0,1,2,3 in order.
REQ-037 Full with push and pop: full buffer, rdy_i=1 and out_ready=1 for 3 cycles -> count_o stays 4, overflow_o stays 0, and order is preserved across pointer wrap.
REQ-038 Zero divisor (DIV_ZERO_FLAG_EN defined): push divisor=0, q=3, r=1 -> div_zero_o=1, quotient_o=7, remainder_o=1; with the macro undefined -> div_zero_o=0, quotient_o=3.
REQ-039 Overflow clear race: clr_ovf=1 in the same cycle as a drop -> overflow_o=1; clr_ovf alone on the next cycle -> 0.
REQ-040 Reset mid-stream: 3 entries buffered, pulse rstn low -> out_valid=0 and count_o=0 immediately; the next push appears alone.
